ps2_rx_decoder: RTL
===================

Name: ps2_rx_decoder

Overview:
- Upstream stage of keyboard_input. Deserialises raw PS/2 device frames (ps2_clk/ps2_dat pins) into validated scan-code bytes.
- Outputs the current byte, the previous byte and a one-cycle "byte received" strobe.
- keyboard_input consumes ps2_key_data, ps2_key_pressed and ps2_out directly; break-code (F0) detection downstream depends on ps2_out.

Parameters:
- FILTER_LEN, 8: consecutive identical synchronised samples required before the filtered ps2_clk changes level.
- TIMEOUT_CYCLES, 50000: clock cycles without a filtered falling edge before a partial frame is aborted (1 ms at 50 MHz).

Ports:
- clock  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- ps2_clk  in  1  raw PS/2 clock pin, asynchronous to clock
- ps2_dat  in  1  raw PS/2 data pin, asynchronous to clock
- ps2_key_data  out  8  most recent valid byte
- ps2_key_pressed  out  1  one-cycle strobe when ps2_key_data updates
- ps2_out  out  8  byte received before ps2_key_data
- key_release  out  1  one-cycle strobe: new byte is non-F0 and previous byte was F0
- key_extended  out  1  level: previous byte was E0 (valid while ps2_key_pressed)
- frame_err  out  1  one-cycle strobe on parity, stop-bit or timeout error

Behaviour:
- Reset (async assert, sync release):
  - State returns to IDLE; shift register, bit counter and timeout counter clear.
  - Filtered clock is forced to 1; all outputs are 0.
- Input conditioning:
  - ps2_clk and ps2_dat each pass through a 2-FF synchroniser.
  - The filtered clock changes level only after FILTER_LEN equal samples. Shorter pulses are ignored.
  - fall_edge is a one-cycle pulse on a filtered 1->0 transition.
  - ps2_dat is sampled only on fall_edge, using its synchronised value.
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on fall_edge with dat=0 (start bit) -> DATA with bitcnt=0. A fall_edge with dat=1 is ignored.
  - DATA: on fall_edge, shift dat in LSB-first and increment bitcnt. After the 8th bit -> PARITY.
  - PARITY: on fall_edge, latch dat -> STOP.
  - STOP: on fall_edge, a frame is valid if dat=1 and popcount(data)+parity is odd. Always -> IDLE.
- Valid frame (outputs update the cycle after the stop-bit fall_edge):
  - ps2_out <= old ps2_key_data; ps2_key_data <= new byte; ps2_key_pressed=1 for exactly one cycle.
  - key_release=1 that same cycle if old ps2_key_data==8'hF0 and new byte!=8'hF0.
  - key_extended=1 if old ps2_key_data==8'hE0.
- Invalid frame (parity or stop error):
  - frame_err=1 for one cycle, at the same latency as a valid frame.
  - ps2_key_data, ps2_out and ps2_key_pressed are unchanged.
- Timeout:
  - The counter runs in every state except IDLE and clears on each fall_edge.
  - On reaching TIMEOUT_CYCLES-1: -> IDLE and frame_err=1 for one cycle.
  - Counter width is clog2(TIMEOUT_CYCLES); it saturates and never wraps.
- Back-to-back frames: the next start bit is accepted on the first fall_edge after STOP. No idle gap is required.
- Latency from raw pin falling edge to fall_edge: 2 synchroniser cycles + FILTER_LEN cycles, ±1 cycle.
- Strobes ps2_key_pressed, key_release and frame_err are never asserted in the same cycle as each other, except ps2_key_pressed with key_release.
- Reset mid-frame: the partial frame is discarded with no strobes. The previous byte history clears to 0.

Decomposition:
- Shared package ps2_pkg holds:
  - FSM state enum (IDLE/DATA/PARITY/STOP)
  - constants PS2_BREAK=8'hF0, PS2_EXT=8'hE0
  - key-code constants shared with keyboard_input: A–H, 1–8, arrows, R
- Sub-module ps2_clk_filter contains the synchroniser, the FILTER_LEN debounce counter and fall_edge generation. It is instantiated once for ps2_clk; ps2_dat uses a plain 2-FF synchroniser.

Test Plan:
- Single frame 0x1C: start 0, data 0,0,1,1,1,0,0,0, parity 0, stop 1.
  - Required: ps2_key_data=8'h1C, ps2_key_pressed high exactly 1 cycle, ps2_out=8'h00, frame_err=0.
- Frames 0x1C, 0xF0, 0x1C:
  - After the third frame: ps2_out=8'hF0, ps2_key_data=8'h1C, key_release pulses once with ps2_key_pressed.
  - key_release stays 0 on the 0xF0 frame itself.
- Frame 0x1C with parity bit 1:
  - Required: frame_err one-cycle pulse, no ps2_key_pressed, ps2_key_data unchanged.
  - A following good 0x32 frame is accepted normally.
- Start + 4 data bits, then ps2_clk held high for TIMEOUT_CYCLES+10:
  - Required: frame_err pulse, FSM returns to IDLE.
  - A subsequent full 0x16 frame yields ps2_key_data=8'h16.
- ps2_clk low glitch of FILTER_LEN-2 cycles in IDLE and inside DATA:
  - Required: no bit shifted; the following frame 0x24 decodes correctly.
- reset_n asserted after the 5th data bit:
  - Required: all outputs 0 immediately, no strobe.
  - The next frame 0x2D decodes with ps2_out=8'h00.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: receiver FSM states, protocol bytes, scan codes used by keyboard_input.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_e;

  localparam logic [7:0] PS2_BREAK = 8'hF0;
  localparam logic [7:0] PS2_EXT   = 8'hE0;

  // Set-2 make codes consumed by keyboard_input
  localparam logic [7:0] KEY_A = 8'h1C;
  localparam logic [7:0] KEY_B = 8'h32;
  localparam logic [7:0] KEY_C = 8'h21;
  localparam logic [7:0] KEY_D = 8'h23;
  localparam logic [7:0] KEY_E = 8'h24;
  localparam logic [7:0] KEY_F = 8'h2B;
  localparam logic [7:0] KEY_G = 8'h34;
  localparam logic [7:0] KEY_H = 8'h33;
  localparam logic [7:0] KEY_1 = 8'h16;
  localparam logic [7:0] KEY_2 = 8'h1E;
  localparam logic [7:0] KEY_3 = 8'h26;
  localparam logic [7:0] KEY_4 = 8'h25;
  localparam logic [7:0] KEY_5 = 8'h2E;
  localparam logic [7:0] KEY_6 = 8'h36;
  localparam logic [7:0] KEY_7 = 8'h3D;
  localparam logic [7:0] KEY_8 = 8'h3E;
  localparam logic [7:0] KEY_R = 8'h2D;
  // Arrow keys arrive behind an E0 prefix
  localparam logic [7:0] KEY_UP    = 8'h75;
  localparam logic [7:0] KEY_DOWN  = 8'h72;
  localparam logic [7:0] KEY_LEFT  = 8'h6B;
  localparam logic [7:0] KEY_RIGHT = 8'h74;

  // PS/2 uses odd parity over the 8 data bits plus the parity bit
  function automatic logic frame_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_clk_filter.sv
// Synchronises and debounces the raw PS/2 clock pin, emitting a pulse on each filtered falling edge.
// Latency: pin edge to fall_edge_o is 2 sync cycles + FILTER_LEN cycles.
// Backpressure: none; fall_edge_o is a single-cycle pulse that is not held.
//
// Ports: clock/reset_n (async active-low), pin_i raw async pin, fall_edge_o one-cycle pulse.
module ps2_clk_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clock,
  input  logic reset_n,
  input  logic pin_i,
  output logic fall_edge_o
);

  localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(FILTER_LEN - 1);

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          filt_q, filt_d;
  logic          fall_q, fall_d;

  // Count consecutive samples that disagree with the filtered level; any
  // agreeing sample restarts the count, so pulses shorter than FILTER_LEN vanish.
  always_comb begin
    cnt_d  = cnt_q;
    filt_d = filt_q;
    if (sync_q[1] == filt_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      cnt_d  = '0;
      filt_d = sync_q[1];
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
    fall_d = filt_q & ~filt_d;
  end

  // Line idles high, so reset the synchroniser and filter high to avoid a false edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= 2'b11;
      cnt_q  <= '0;
      filt_q <= 1'b1;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], pin_i};
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
      fall_q <= fall_d;
    end
  end

  assign fall_edge_o = fall_q;

endmodule

// File: rtl/ps2_rx_decoder.sv
// Deserialises PS/2 device frames into checked scan-code bytes with current/previous byte history.
// Latency: outputs update one cycle after the filtered stop-bit edge (pin + 2 + FILTER_LEN + 1).
// Backpressure: none; strobes are single-cycle and the consumer must sample them when they fire.
//
// Ports: clock, reset_n (async active-low), ps2_clk/ps2_dat raw pins;
//        ps2_key_data/ps2_out current/previous byte, ps2_key_pressed/key_release/frame_err strobes,
//        key_extended level (previous byte was E0).
module ps2_rx_decoder
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] ps2_key_data,
  output logic       ps2_key_pressed,
  output logic [7:0] ps2_out,
  output logic       key_release,
  output logic       key_extended,
  output logic       frame_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);

  logic       fall_edge;
  logic [1:0] dat_sync_q;
  logic       dat;

  ps2_state_e    state_q, state_d;
  logic [2:0]    bitcnt_q, bitcnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic [TW-1:0] tout_q, tout_d;
  logic          frame_ok, frame_bad;

  logic [7:0] key_data_q, out_q;
  logic       pressed_q, release_q, ext_q, err_q;

  ps2_clk_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
    .clock       (clock),
    .reset_n     (reset_n),
    .pin_i       (ps2_clk),
    .fall_edge_o (fall_edge)
  );

  // Data needs no debounce: the device holds it stable long before the clock falls.
  assign dat = dat_sync_q[1];

  always_comb begin
    state_d   = state_q;
    bitcnt_d  = bitcnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    tout_d    = (state_q == IDLE) ? '0 : ((tout_q == TMAX) ? tout_q : tout_q + 1'b1);
    frame_ok  = 1'b0;
    frame_bad = 1'b0;

    case (state_q)
      IDLE: begin
        if (fall_edge && !dat) begin
          state_d  = DATA;
          bitcnt_d = '0;
        end
      end
      DATA: begin
        if (fall_edge) begin
          shift_d  = {dat, shift_q[7:1]};
          bitcnt_d = bitcnt_q + 1'b1;
          if (bitcnt_q == 3'd7) state_d = PARITY;
        end
      end
      PARITY: begin
        if (fall_edge) begin
          par_d   = dat;
          state_d = STOP;
        end
      end
      STOP: begin
        if (fall_edge) begin
          state_d = IDLE;
          if (dat && frame_parity_ok(shift_q, par_q)) frame_ok  = 1'b1;
          else                                        frame_bad = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // An edge always wins over the timeout, so a stop-bit edge can never
    // coincide with a timeout error.
    if (fall_edge) begin
      tout_d = '0;
    end else if (state_q != IDLE && tout_q == TMAX) begin
      state_d   = IDLE;
      tout_d    = '0;
      frame_bad = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      dat_sync_q <= 2'b11;
      state_q    <= IDLE;
      bitcnt_q   <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      tout_q     <= '0;
    end else begin
      dat_sync_q <= {dat_sync_q[0], ps2_dat};
      state_q    <= state_d;
      bitcnt_q   <= bitcnt_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      tout_q     <= tout_d;
    end
  end

  // Byte history and strobes; history only moves on a good frame.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      key_data_q <= '0;
      out_q      <= '0;
      pressed_q  <= 1'b0;
      release_q  <= 1'b0;
      ext_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      pressed_q <= frame_ok;
      release_q <= frame_ok && (key_data_q == PS2_BREAK) && (shift_q != PS2_BREAK);
      err_q     <= frame_bad;
      if (frame_ok) begin
        out_q      <= key_data_q;
        key_data_q <= shift_q;
        ext_q      <= (key_data_q == PS2_EXT);
      end
    end
  end

  assign ps2_key_data    = key_data_q;
  assign ps2_out         = out_q;
  assign ps2_key_pressed = pressed_q;
  assign key_release     = release_q;
  assign key_extended    = ext_q;
  assign frame_err       = err_q;

endmodule
